// File: rtl/fir_pkg.sv
// Shared helpers for the symmetric FIR: width functions and the default coefficient set.
package fir_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        int v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    // Exact accumulator width: pre-add grows one bit, the sum of TAPS/2 products grows clog2(TAPS/2).
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + 1 + cw + clog2(taps / 2);
    endfunction

    function automatic int coef_addr_width(input int taps);
        return (clog2(taps / 2) < 1) ? 1 : clog2(taps / 2);
    endfunction

    localparam int DEFAULT_COEF [4] = '{29, -53, -52, 40};

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, commit copies it to the active bank.
module fir_coef_bank import fir_pkg::*; #(
    parameter  int TAPS = 8,
    parameter  int CW   = 8,
    localparam int NC   = TAPS / 2,
    localparam int CAW  = coef_addr_width(TAPS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 coef_we,
    input  logic [CAW-1:0]       coef_addr,
    input  logic [CW-1:0]        coef_wdata,
    input  logic                 coef_commit,
    output logic [NC*CW-1:0]     active_o
);

    logic [CW-1:0] shadow_q [NC];
    logic [CW-1:0] shadow_d [NC];
    logic [CW-1:0] active_q [NC];
    logic [CW-1:0] active_d [NC];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        // Commit copies shadow_q, so a write in the same cycle is not visible to it.
        if (coef_commit) active_d = shadow_q;
        for (int k = 0; k < NC; k++) begin
            if (coef_we && coef_addr == CAW'(k)) shadow_d[k] = coef_wdata;
        end
    end

    // NOTE: both banks are plain registers, not RAM, so they can and do clear on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NC; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar k = 0; k < NC; k++) begin : g_flat
        assign active_o[k*CW +: CW] = active_q[k];
    end

endmodule

// File: rtl/fir_sym_pipe.sv
// Pipelined symmetric FIR: pre-add, multiply, sum/shift/narrow, three register stages.
// Define FIR_SAT_EN to saturate the narrowed output and drive sat_flag.
module fir_sym_pipe import fir_pkg::*; #(
    parameter  int TAPS  = 8,
    parameter  int DW    = 7,
    parameter  int CW    = 8,
    parameter  int OW    = 16,
    parameter  int SHIFT = 0,
    localparam int CAW   = coef_addr_width(TAPS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x_n,
    input  logic                 coef_we,
    input  logic [CAW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 coef_commit,
    output logic                 out_valid,
    output logic signed [OW-1:0] y_n,
    output logic                 sat_flag
);

    localparam int NC = TAPS / 2;
    localparam int SW = DW + 1;
    localparam int PW = DW + 1 + CW;
    localparam int AW = acc_width(DW, CW, TAPS);
    localparam int EW = (AW > OW) ? AW : OW;

    logic [NC*CW-1:0] coef_flat;

    fir_coef_bank #(.TAPS(TAPS), .CW(CW)) u_coef_bank (
        .clk         (clk),
        .resetn      (resetn),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .active_o    (coef_flat)
    );

    logic signed [DW-1:0] dl_q [TAPS-1];
    logic signed [DW-1:0] win  [TAPS];
    logic                 v1_q, v2_q;

    always_comb begin
        win[0] = x_n;
        for (int k = 1; k < TAPS; k++) win[k] = dl_q[k-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < TAPS - 1; k++) dl_q[k] <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (in_valid) begin
                dl_q[0] <= x_n;
                for (int k = 1; k < TAPS - 1; k++) dl_q[k] <= dl_q[k-1];
            end
            v1_q <= in_valid;
            v2_q <= v1_q;
        end
    end

    for (genvar k = 0; k < NC; k++) begin : g_tap
        logic signed [SW-1:0] s_d, s_q;
        logic signed [CW-1:0] h;
        logic signed [PW-1:0] p_d, p_q;
        logic signed [AW-1:0] part;

        assign s_d = SW'(win[k]) + SW'(win[TAPS-1-k]);
        assign h   = coef_flat[k*CW +: CW];
        assign p_d = PW'(s_q) * PW'(h);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s_q <= '0;
                p_q <= '0;
            end else begin
                if (in_valid) s_q <= s_d;
                if (v1_q)     p_q <= p_d;
            end
        end

        // Running sum across taps; the last element is the full accumulator.
        if (k == 0) begin : g_head
            assign part = AW'(p_q);
        end else begin : g_tail
            assign part = g_tap[k-1].part + AW'(p_q);
        end
    end

    logic signed [AW-1:0] acc, shifted;
    logic signed [EW-1:0] ext;
    logic signed [OW-1:0] y_d, y_q;
    logic                 out_valid_q;

    assign acc     = g_tap[NC-1].part;
    assign shifted = acc >>> SHIFT;
    assign ext     = EW'(shifted);

`ifdef FIR_SAT_EN
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    logic sat_d, sat_q;

    always_comb begin
        y_d   = ext[OW-1:0];
        sat_d = 1'b0;
        if (ext > SAT_MAX) begin
            y_d   = SAT_MAX[OW-1:0];
            sat_d = 1'b1;
        end else if (ext < SAT_MIN) begin
            y_d   = SAT_MIN[OW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   sat_q <= 1'b0;
        else if (v2_q) sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`else
    assign y_d      = ext[OW-1:0];
    assign sat_flag = 1'b0;

    // Upper bits are intentionally discarded by the wrap.
    if (EW > OW) begin : g_wrap
        logic unused_hi;
        assign unused_hi = ^ext[EW-1:OW];
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) y_q <= y_d;
        end
    end

    assign y_n       = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_sym_pipe.sv
// Directed bench for fir_sym_pipe: a reference model fills a scoreboard checked every cycle.
module tb_fir_sym_pipe;
    import fir_pkg::*;

    localparam int TAPS = 8;
    localparam int NC   = TAPS / 2;

`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [6:0] x_n = '0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic signed [7:0] coef_wdata = '0;
    logic              coef_commit = 1'b0;

    logic               out_valid, sat_flag, out_valid8, sat_flag8;
    logic signed [15:0] y_n;
    logic signed [7:0]  y_n8;

    always #5 clk = ~clk;

    fir_sym_pipe #(.TAPS(TAPS), .DW(7), .CW(8), .OW(16), .SHIFT(0)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .x_n(x_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .out_valid(out_valid), .y_n(y_n), .sat_flag(sat_flag)
    );

    fir_sym_pipe #(.TAPS(TAPS), .DW(7), .CW(8), .OW(8), .SHIFT(0)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .x_n(x_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .out_valid(out_valid8), .y_n(y_n8), .sat_flag(sat_flag8)
    );

    typedef struct {
        int due;
        int y16;
        int y8;
        bit s16;
        bit s8;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   shadow_m [NC];
    int   active_m [NC];
    int   hist_m [TAPS-1];
    int   last16 = 0, last8 = 0;
    bit   lasts16 = 1'b0, lasts8 = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int narrow(input longint acc, input int ow, input bit sat, output bit clip);
        longint mx = (64'sd1 <<< (ow - 1)) - 1;
        longint mn = -mx - 1;
        longint m;
        clip = 1'b0;
        if (sat) begin
            if (acc > mx) begin clip = 1'b1; return int'(mx); end
            if (acc < mn) begin clip = 1'b1; return int'(mn); end
            return int'(acc);
        end
        m = acc & ((64'sd1 <<< ow) - 1);
        if (m > mx) m = m - (64'sd1 <<< ow);
        return int'(m);
    endfunction

    task automatic monitor();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("out_valid", out_valid, 1);
            check("out_valid8", out_valid8, 1);
            check("y_n", y_n, e.y16);
            check("y_n8", y_n8, e.y8);
            check("sat_flag", sat_flag, e.s16);
            check("sat_flag8", sat_flag8, e.s8);
            last16 = e.y16; last8 = e.y8; lasts16 = e.s16; lasts8 = e.s8;
        end else begin
            check("out_valid_idle", out_valid, 0);
            check("out_valid8_idle", out_valid8, 0);
            check("y_n_hold", y_n, last16);
            check("y_n8_hold", y_n8, last8);
            check("sat_flag_hold", sat_flag, lasts16);
            check("sat_flag8_hold", sat_flag8, lasts8);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit v, input int x, input bit we, input int addr,
                        input int wd, input bit cm);
        exp_t   e;
        int     w [TAPS];
        longint acc;
        in_valid = v; x_n = 7'(x); coef_we = we; coef_addr = 2'(addr);
        coef_wdata = 8'(wd); coef_commit = cm;
        if (cm) active_m = shadow_m;
        if (we) shadow_m[addr] = wd;
        if (v) begin
            w[0] = x;
            for (int k = 1; k < TAPS; k++) w[k] = hist_m[k-1];
            acc = 0;
            for (int k = 0; k < NC; k++) acc += longint'(active_m[k]) * (w[k] + w[TAPS-1-k]);
            e.due = cyc + 3;
            e.y16 = narrow(acc, 16, SAT, e.s16);
            e.y8  = narrow(acc, 8, SAT, e.s8);
            sb.push_back(e);
            for (int k = TAPS - 2; k > 0; k--) hist_m[k] = hist_m[k-1];
            hist_m[0] = x;
        end
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic send(input bit v, input int x);
        step(v, x, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0);
    endtask

    task automatic impulse_train(input int zeros);
        send(1'b1, 1);
        repeat (zeros) send(1'b1, 0);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        in_valid = 1'b0; x_n = '0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; coef_commit = 1'b0;
        for (int k = 0; k < NC; k++) begin shadow_m[k] = 0; active_m[k] = 0; end
        for (int k = 0; k < TAPS - 1; k++) hist_m[k] = 0;
        sb.delete();
        last16 = 0; last8 = 0; lasts16 = 1'b0; lasts8 = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y_n", y_n, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_y_n8", y_n8, 0);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #1;
        do_reset(2);
        idle(2);

        // Test 1: program defaults, impulse response.
        for (int k = 0; k < NC; k++) step(1'b0, 0, 1'b1, k, DEFAULT_COEF[k], 1'b0);
        step(1'b0, 0, 1'b0, 0, 0, 1'b1);
        impulse_train(10);
        idle(3);

        // Tests 2 and 3: constant -64, steady state on both widths.
        repeat (12) send(1'b1, -64);
        idle(4);
        check("steady_y16", y_n, 4608);
        check("steady_y8", y_n8, SAT ? 127 : 0);
        check("steady_sat8", sat_flag8, SAT ? 1 : 0);
        check("steady_sat16", sat_flag, 0);
        repeat (8) send(1'b1, 0);
        idle(3);

        // Test 4: shadow write without commit, then commit racing a write.
        step(1'b0, 0, 1'b1, 0, 1, 1'b0);
        impulse_train(9);
        step(1'b0, 0, 1'b1, 0, 5, 1'b1);
        impulse_train(9);
        step(1'b0, 0, 1'b0, 0, 0, 1'b1);
        impulse_train(9);
        idle(3);

        // Test 5: gapped valid pattern 1,0,0,1,...
        send(1'b1, 1);
        repeat (8) begin
            send(1'b0, 0);
            send(1'b0, 0);
            send(1'b1, 0);
        end
        idle(4);

        // Test 6: reset with samples in flight, then zero output until reprogrammed.
        send(1'b1, 10);
        send(1'b1, -20);
        send(1'b1, 30);
        do_reset(1);
        monitor();
        send(1'b1, 63);
        send(1'b1, -64);
        repeat (6) send(1'b1, 17);
        idle(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sym_pipe.md
Name: fir_sym_pipe

Overview:
- Parametrised, pipelined, linear-phase (symmetric) FIR filter. Generalises the fixed 8-tap, 7-bit filter.
- Configurable tap count and data, coefficient and output widths.
- Coefficients are run-time programmable through a double-buffered bank with atomic commit.
- Has a valid qualifier, configurable output scaling and an optional saturation stage.
- Sits between sample source and downstream DSP, which consumes y_n when out_valid is high.

Parameters:
- TAPS, 8, filter length; even, >= 2; TAPS/2 unique coefficients.
- DW, 7, signed input sample width.
- CW, 8, signed coefficient width.
- OW, 16, signed output width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  x_n is a new sample this cycle; no backpressure.
- x_n  in  DW  signed input sample.
- coef_we  in  1  write coef_wdata into shadow coefficient coef_addr.
- coef_addr  in  CAW  shadow index 0..TAPS/2-1, where CAW = max(1, clog2(TAPS/2)).
- coef_wdata  in  CW  signed coefficient value.
- coef_commit  in  1  copy whole shadow bank into active bank.
- out_valid  out  1  y_n holds a new result this cycle.
- y_n  out  OW  signed filter output.
- sat_flag  out  1  y_n was clipped; always 0 without the optional feature.

Behaviour:
- Reset (async assert, sync release): delay line, all pipeline registers, shadow and active coefficient banks, y_n, out_valid and sat_flag all go to 0.
- Delay line: TAPS-1 registers of DW bits. They shift only on cycles where in_valid=1.
- Window w[0]=x_n, w[k]=k-th previous accepted sample. Before TAPS-1 samples are accepted, missing history is 0.
- Stage 1, edge of the accepting cycle: S[k] = w[k] + w[TAPS-1-k] for k=0..TAPS/2-1, at DW+1 bits and exact.
- Stage 2: P[k] = S[k] * h_active[k], signed, DW+1+CW bits.
- Stage 3: sum all P[k] into AW = DW+1+CW+clog2(TAPS/2) bits, exact and never overflowing. Then arithmetic-shift right by SHIFT (floor). Then narrow to OW.
- Narrowing without saturation: keep the low OW bits (two's-complement wrap).
- Latency: a sample accepted in cycle t gives out_valid=1 in cycle t+3, for exactly one cycle per accepted sample.
- Throughput is one sample per clock.
- Each stage register loads only when its incoming valid bit is 1, otherwise it holds. y_n holds its last value while out_valid=0.
- Coefficients:
  - coef_we writes the shadow entry at the edge.
  - coef_commit copies all shadow entries into the active bank at the edge.
  - Stage 2 uses the active bank as of that edge. Products formed in the cycle after a commit use the new coefficients; samples already in stage 3 are unaffected.
  - coef_we and coef_commit in the same cycle: commit copies the pre-write shadow contents. The write lands in shadow only.
  - Out-of-range coef_addr (TAPS/2 not a power of 2) is ignored.
- Reset mid-operation discards all in-flight samples. No out_valid is produced for them.

Optional Feature:
- FIR_SAT_EN defined:
  - The narrowing step saturates to [-2^(OW-1), 2^(OW-1)-1].
  - sat_flag is registered with y_n. It is 1 on an out_valid cycle whose value was clipped, and holds with y_n otherwise.
- FIR_SAT_EN undefined: wrap as above; sat_flag is tied to 0.

Decomposition:
- Package fir_pkg:
  - clog2 function.
  - Width helpers for AW and CAW.
  - Default coefficient constant array {29, -53, -52, 40} for bench use.
- Sub-module fir_coef_bank:
  - Shadow and active registers, write/commit logic, and the same-cycle rule.
  - Exposes the active bank as a flat bus.
- Pre-add, multiply and adder tree stay in the top module, written as generate loops.

Test Plan:
1. Defaults. Program 29, -53, -52, 40 and commit. Send impulse x_n=1, then zeros, each with in_valid=1. From 3 cycles after the impulse, y_n = 29, -53, -52, 40, 40, -52, -53, 29, then 0.
2. Constant x_n=-64 for 8+ samples, same coefficients. Steady-state y_n = 4608.
3. OW=8, SHIFT=0, same stimulus as 2:
   - With FIR_SAT_EN: y_n=127, sat_flag=1.
   - Without FIR_SAT_EN: y_n=0 (4608 mod 256), sat_flag=0.
4. Write shadow h0=1 without commit, then send an impulse. Output still starts with 29. Then assert coef_commit together with coef_we h0=5, followed by a new impulse. Output starts with 1 (not 5); a second commit gives 5.
5. Impulse sequence with in_valid toggled 1,0,0,1,... Same value sequence as test 1. out_valid follows the valid pattern delayed by 3, and y_n holds during gaps.
6. Assert resetn=0 for 1 cycle with samples in flight. All outputs 0, no out_valid for those samples, coefficients cleared. Subsequent outputs are 0 until reprogrammed.
